// File: rtl/isqrt_search_if.sv
// Valid/ready bundle carrying an operand from the discriminant stage into isqrt_search
// and the finished root out to the hit-distance stage.
interface isqrt_search_if #(
    parameter int W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   in_value;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_root;

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_root
    );

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_root
    );
endinterface

// File: rtl/isqrt_search.sv
// Bit-serial floor(sqrt(c)) for a 2*W-bit operand: one root bit per clock, MSB first,
// each bit kept only if the trial root squared does not exceed the latched operand.

module squarer #(
    parameter int W = 32
) (
    input  logic [W-1:0]   a_i,
    input  logic [2*W-1:0] c_i,
    output logic           gt_o
);
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] sq;

    // (2^W-1)^2 fits in 2*W bits, so the product never truncates.
    assign a_ext = {{W{1'b0}}, a_i};
    assign sq    = a_ext * a_ext;
    assign gt_o  = sq > c_i;
endmodule

module isqrt_search #(
    parameter int W = 32
) (
    input logic                clk,
    input logic                rst,
    isqrt_search_if.slave      bus
);
    localparam int IW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [W-1:0]     root_q;
    logic [2*W-1:0]   c_q;
    logic [IW-1:0]    bit_idx_q;
    logic             out_valid_q;
    logic [W-1:0]     out_root_q;

    logic [W-1:0]     trial;
    logic             trial_gt;
    logic [W-1:0]     root_d;

    assign trial  = root_q | (W'(1) << bit_idx_q);
    assign root_d = trial_gt ? root_q : trial;

    squarer #(.W(W)) u_squarer (
        .a_i  (trial),
        .c_i  (c_q),
        .gt_o (trial_gt)
    );

    // NOTE: every register here uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            root_q      <= '0;
            c_q         <= '0;
            bit_idx_q   <= IW'(W - 1);
            out_valid_q <= 1'b0;
            out_root_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        c_q       <= bus.in_value;
                        root_q    <= '0;
                        bit_idx_q <= IW'(W - 1);
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    root_q <= root_d;
                    if (bit_idx_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_root_q  <= root_d;
                    end else begin
                        bit_idx_q <= bit_idx_q - IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gating with rst keeps the source from seeing a ready block while it is held in reset.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_root  = out_root_q;
endmodule

// File: doc/isqrt_search.md
# isqrt_search

Sequential floor square root unit for the ray-sphere intersection path. It computes floor(sqrt(c)) for a 64-bit unsigned operand using a bit-serial binary search, resolving one result bit per clock. Each step checks a trial root with an internal `squarer` comparison (trial*trial > c). It sits downstream of the discriminant calculation and hands the root to the hit-distance stage over a valid/ready handshake.

## Interface
- `W`, 32: result width. Operand width is 2*W; only W=32 is required to work.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operand present on `in_value`
- `in_ready`  out  1  block can accept an operand
- `in_value`  in  64  unsigned operand c
- `out_valid`  out  1  `out_root` holds a finished result
- `out_ready`  in  1  downstream accepts the result
- `out_root`  out  32  floor(sqrt(c))

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready` at a clock edge: latch `in_value` into `c_reg`, clear `root` to 0, set `bit_idx`=W-1, go to RUN.
- **RUN**
  - Each cycle: trial = `root` | (1<<`bit_idx`).
  - If trial*trial > `c_reg`, `root` is unchanged. Otherwise `root` = trial.
  - The product is the full 64-bit value; 0xFFFFFFFF² < 2^64, so there is no truncation.
  - The comparison is one `squarer` instance, with a = trial and c = `c_reg`.
  - If `bit_idx`==0 on this cycle, go to DONE. Otherwise decrement `bit_idx`.
- **DONE**
  - `out_valid`=1 and `out_root`=`root`.
  - On `out_ready`=1 at a clock edge, go to IDLE.
  - `out_root` is held stable until the transfer.
- `in_ready`=0 in RUN and DONE. Operands offered there are not taken; the source must hold them.
- `in_value` is sampled only on the accept edge. Later changes to it do not affect the result in progress.
- The result is exact: `root`² ≤ c < (`root`+1)² for every 64-bit c.

## Timing
- Reset, asynchronous while `rst`=1:
  - state=IDLE, `root`=0, `c_reg`=0, `bit_idx`=W-1.
  - `out_valid`=0, `out_root`=0.
  - `in_ready`=0 while `rst` is high; `in_ready`=1 from the first cycle after release.
- Latency:
  - Operand accepted at edge k.
  - RUN occupies edges k+1 … k+W, one bit per edge, MSB first.
  - `out_valid` rises after edge k+W, i.e. W cycles after acceptance.
- Throughput:
  - With `out_ready` tied high, DONE lasts one cycle and IDLE at least one cycle.
  - Back-to-back operands are therefore accepted every W+2 cycles (34).
- Backpressure: DONE persists indefinitely while `out_ready`=0. `out_root` and `out_valid` do not change.
- `out_ready` outside DONE is ignored. `in_valid` outside IDLE is ignored.
- Reset mid-operation (RUN or DONE):
  - The in-flight result is discarded and no `out_valid` pulse is produced.
  - The next accepted operand computes from scratch.
- `out_valid` and `in_ready` are state decodes with no combinational path from the `in_valid`/`out_ready` inputs.
- The `squarer` path (32x32 multiply plus 64-bit compare) is single-cycle and registered into `root`.

## Test plan
- **Reset check:** hold `rst` for 3 cycles, then release.
  - During reset: `out_valid`=0, `out_root`=0, `in_ready`=0.
  - Cycle after release: `in_ready`=1.
- **Boundary operands, `out_ready`=1:**
  - c=0 → 0.
  - c=1 → 1.
  - c=2 → 1.
  - c=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFF.
  - Each result has `out_valid` exactly 32 cycles after its accept edge.
- **Perfect squares and neighbours:**
  - c=99 → 9.
  - c=100 → 10.
  - c=0xFFFFFFFE00000001 → 0xFFFFFFFF.
  - c=0xFFFFFFFE00000000 → 0xFFFFFFFE.
- **Backpressure:**
  - c=1000000, hold `out_ready`=0 for 10 cycles after `out_valid`: `out_root`=1000 stays stable and `in_ready`=0 throughout.
  - Release `out_ready`: `in_ready`=1 on the next cycle.
- **Stream with source stall:**
  - `in_valid` held high with new operands, `in_value` changed during RUN.
  - Results match the latched operands, not the changed values.
  - Accepts are spaced exactly 34 cycles apart.
- **Reset mid-RUN and random check:**
  - Assert `rst` at cycle 15 of RUN: no `out_valid` appears, then c=144 → 12.
  - Follow with 10k random c values checked against the root² ≤ c < (root+1)² reference.
